// File: rtl/alu_arb_pkg.sv
// Shared constants and state encoding for the ALU arbiter.
package alu_arb_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1, wrapping.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last) + k) % NREQ;
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = IDW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ALU among NREQ requesters; one op in flight, response at accept+2.
// Optional counters enabled by ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
`ifdef ALU_ARB_STATS_EN
    output logic [16*NREQ-1:0] stat_grants,
    output logic [15:0]        stat_stall,
`endif
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0]  req_ctrl,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_result,
    output logic [3:0]         rsp_flags,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [2:0]         alu_ctrl,
    input  logic [31:0]        alu_result,
    input  logic [3:0]         alu_flags
);

    state_t          state;
    logic [IDW-1:0]  last;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  g_idx;
    logic            any;
    logic            take;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [2:0]      sel_ctrl;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (req_valid),
        .last  (last),
        .grant (grant),
        .idx   (g_idx),
        .any   (any)
    );

    assign take      = (state == IDLE) && any && !reset;
    assign req_ready = take ? grant : '0;

    // Grant is one-hot, so an OR-mux selects the winner's operands.
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a    = sel_a    | req_a[32*i +: 32];
                sel_b    = sel_b    | req_b[32*i +: 32];
                sel_ctrl = sel_ctrl | req_ctrl[3*i +: 3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last       <= IDW'(NREQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        alu_a    <= sel_a;
                        alu_b    <= sel_b;
                        alu_ctrl <= sel_ctrl;
                        rsp_id   <= g_idx;
                        last     <= g_idx;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (take && grant[i] && stat_grants[16*i +: 16] != 16'hFFFF)
                    stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
            end
            if (state == RESP && !rsp_ready && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule
